regfile_bypass_sb: RTL and testbench
====================================

Name: regfile_bypass_sb

Overview:
- Parametrised integer register file for the RV32 monocycle/pipelined core. Generalises the existing 32x32 file in width and depth.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard for multi-cycle producers (mul/div, loads).
- Sits between decode (read/issue) and writeback (write). Decode stalls on busy1/busy2.

Parameters:
- XLEN, 32, register data width in bits.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- AW, $clog2(NREGS), register index width (derived; do not override).
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- rs1  input  AW  read address port 1.
- rs2  input  AW  read address port 2.
- rd1  output  XLEN  read data port 1 (combinational).
- rd2  output  XLEN  read data port 2 (combinational).
- busy1  output  1  scoreboard bit of rs1 (combinational, after write-clear bypass).
- busy2  output  1  scoreboard bit of rs2.
- iss_en  input  1  issue strobe: mark iss_rd as pending.
- iss_rd  input  AW  destination register of issued instruction.
- wr_en  input  1  writeback enable.
- rd  input  AW  writeback destination.
- wr_data  input  XLEN  writeback data.

Behaviour:
- Storage: NREGS x XLEN array plus NREGS busy bits.
- One clock (clk). Reset is synchronous, active-high (rst). No other reset.
- Reset:
  - On a clk edge with rst=1, all registers go to 0 and all busy bits go to 0.
  - rst has priority over wr_en and iss_en in the same cycle.
  - Reset mid-operation discards pending writebacks. Outstanding busy bits are dropped.
  - Outputs are combinational from state, so after reset rd1=rd2=0 and busy1=busy2=0 for any address.
- Write:
  - At the edge, if wr_en and not (ZERO_REG and rd==0), then reg[rd] <= wr_data and busy[rd] <= 0.
  - Writing a non-busy register is legal: data is stored and busy stays 0.
- Issue:
  - At the edge, if iss_en and not (ZERO_REG and iss_rd==0), then busy[iss_rd] <= 1.
  - Same cycle, wr_en with rd==iss_rd: data is written and busy ends at 1. The newer issue wins.
  - Re-issuing an already-busy register keeps it at 1. This is a single bit, not a counter; decode must not issue over a busy rd (WAW is stalled upstream).
- Read, zero-latency combinational, evaluated per port p (rs = rs1 or rs2):
  - If ZERO_REG and rs==0: data=0, busy=0.
  - Else if BYPASS and wr_en and rd==rs: data=wr_data, busy=0. The write completes this cycle; the write-clear is forwarded.
  - Else: data=reg[rs], busy=busy[rs].
- Bypass and issue ordering: iss_en in the current cycle does not affect busyN until the next cycle.
- With BYPASS=0, reads return array contents, so a written value is visible the cycle after the write.
- Both read ports are fully independent. rs1==rs2 returns identical values.
- Width: wr_data is stored unmodified. No sign extension or truncation.
- No X on outputs after the first reset. Before the first reset, contents are undefined.

Test Plan:
- Reset then read: rst=1 for one cycle, then rs1=5, rs2=31 -> rd1=0, rd2=0, busy1=0, busy2=0.
- Write then read: wr_en=1, rd=7, wr_data=0xDEADBEEF. Next cycle rs1=7 -> rd1=0xDEADBEEF. Write to rd=0 with 0x1234 -> rs2=0 reads 0 forever.
- Bypass: same cycle wr_en=1, rd=3, wr_data=0xA5A5A5A5, rs1=3 -> rd1=0xA5A5A5A5 combinationally. With BYPASS=0, rd1 shows the old value 0 that cycle and 0xA5A5A5A5 the next.
- Scoreboard lifecycle:
  - iss_en=1, iss_rd=9 -> next cycle rs2=9 gives busy2=1.
  - Three idle cycles -> busy2 stays 1.
  - wr_en=1, rd=9, wr_data=0x55 -> busy2=0 in that same cycle (bypass), and stays 0 after the edge.
- Simultaneous issue and write to x12:
  - iss_en=1, iss_rd=12, wr_en=1, rd=12, wr_data=0x77 -> next cycle rd1=0x77, busy1=1.
  - iss_en/iss_rd=0 -> busy stays 0.
- Reset mid-operation: busy[4]=1 and reg[4]=0x99. Assert rst together with wr_en=1, rd=4, wr_data=0x11 -> next cycle rd1=0 and busy1=0 for rs1=4.
- Parametrised run: XLEN=64, NREGS=16. Write 0xFFFF_0000_1234_5678 to r15 -> reads back exactly; iss_rd=15 wraps nowhere.

Source files
------------

// File: rtl/regfile_bypass_sb.sv
// Integer register file with same-cycle write bypass and a busy scoreboard.
// Ports: clk/rst; rs1/rs2 -> rd1/rd2 + busy1/busy2; iss_en/iss_rd; wr_en/rd/wr_data.
module regfile_bypass_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            wr_en,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic wr_ok;
  logic iss_ok;

  assign wr_ok  = wr_en && !((ZERO_REG != 0) && (rd == '0));
  assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_rd == '0));

  // Issue is applied after writeback so a same-cycle issue wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)
      busy_d[rd] = 1'b0;
    if (iss_ok)
      busy_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      if (wr_ok)
        regs_q[rd] <= wr_data;
    end
  end

  // Returns {busy, data} for one read port.
  function automatic logic [XLEN:0] rport(
    input logic [AW-1:0] rs
  );
    logic [XLEN:0] r;
    r = {busy_q[rs], regs_q[rs]};
    unique case (1'b1)
      ((ZERO_REG != 0) && (rs == '0)):
        r = '0;
      ((ZERO_REG == 0 || rs != '0)
        && (BYPASS != 0) && wr_en && (rd == rs)):
        r = {1'b0, wr_data};
      default: ;
    endcase
    return r;
  endfunction

  assign {busy1, rd1} = rport(rs1);
  assign {busy2, rd2} = rport(rs2);

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench for regfile_bypass_sb: default, no-bypass and 64x16 builds.
// Checks reset, write/read, bypass, scoreboard lifecycle and reset priority.
module tb_regfile_bypass_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  rs1, rs2, iss_rd, rd;
  logic        iss_en, wr_en;
  logic [31:0] wr_data;

  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_b1, a_b2, b_b1, b_b2;

  logic [3:0]  c_rs1, c_rs2, c_iss_rd, c_rd;
  logic        c_iss_en, c_wr_en;
  logic [63:0] c_wr_data, c_rd1, c_rd2;
  logic        c_b1, c_b2;

  int checks = 0;
  int errors = 0;

  regfile_bypass_sb u_a (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .rd1(a_rd1), .rd2(a_rd2), .busy1(a_b1), .busy2(a_b2),
    .iss_en(iss_en), .iss_rd(iss_rd),
    .wr_en(wr_en), .rd(rd), .wr_data(wr_data)
  );

  regfile_bypass_sb #(.BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .rd1(b_rd1), .rd2(b_rd2), .busy1(b_b1), .busy2(b_b2),
    .iss_en(iss_en), .iss_rd(iss_rd),
    .wr_en(wr_en), .rd(rd), .wr_data(wr_data)
  );

  regfile_bypass_sb #(.XLEN(64), .NREGS(16)) u_c (
    .clk(clk), .rst(rst), .rs1(c_rs1), .rs2(c_rs2),
    .rd1(c_rd1), .rd2(c_rd2), .busy1(c_b1), .busy2(c_b2),
    .iss_en(c_iss_en), .iss_rd(c_iss_rd),
    .wr_en(c_wr_en), .rd(c_rd), .wr_data(c_wr_data)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then let inputs change away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_en = 0; iss_rd = 0; wr_en = 0; rd = 0; wr_data = 0;
    c_iss_en = 0; c_iss_rd = 0; c_wr_en = 0; c_rd = 0; c_wr_data = 0;
  endtask

  initial begin
    idle();
    rs1 = 0; rs2 = 0; c_rs1 = 0; c_rs2 = 0;
    rst = 1;
    tick();
    rst = 0;

    rs1 = 5; rs2 = 31; #1;
    chk("rst_rd1", a_rd1, 0);
    chk("rst_rd2", a_rd2, 0);
    chk("rst_busy1", a_b1, 0);
    chk("rst_busy2", a_b2, 0);
    chk("rst_b_rd2", b_rd2, 0);

    wr_en = 1; rd = 7; wr_data = 32'hDEADBEEF;
    tick();
    idle(); rs1 = 7; #1;
    chk("wr7_a", a_rd1, 32'hDEADBEEF);
    chk("wr7_b", b_rd1, 32'hDEADBEEF);

    wr_en = 1; rd = 0; wr_data = 32'h1234; rs2 = 0; #1;
    chk("x0_byp", a_rd2, 0);
    tick();
    idle(); #1;
    chk("x0_a", a_rd2, 0);
    chk("x0_b", b_rd2, 0);

    wr_en = 1; rd = 3; wr_data = 32'hA5A5A5A5; rs1 = 3; #1;
    chk("byp_a", a_rd1, 32'hA5A5A5A5);
    chk("byp_b_old", b_rd1, 0);
    tick();
    idle(); #1;
    chk("byp_b_new", b_rd1, 32'hA5A5A5A5);

    iss_en = 1; iss_rd = 9; rs2 = 9; #1;
    chk("iss_same_cyc", a_b2, 0);
    tick();
    idle(); #1;
    chk("busy9", a_b2, 1);
    tick(); tick(); tick();
    chk("busy9_hold_a", a_b2, 1);
    chk("busy9_hold_b", b_b2, 1);
    wr_en = 1; rd = 9; wr_data = 32'h55; #1;
    chk("wb9_byp_a", a_b2, 0);
    chk("wb9_nobyp_b", b_b2, 1);
    chk("wb9_data_a", a_rd2, 32'h55);
    tick();
    idle(); #1;
    chk("wb9_after_a", a_b2, 0);
    chk("wb9_after_b", b_b2, 0);
    chk("wb9_rd_b", b_rd2, 32'h55);

    iss_en = 1; iss_rd = 12;
    wr_en = 1; rd = 12; wr_data = 32'h77;
    tick();
    idle(); rs1 = 12; #1;
    chk("x12_rd", a_rd1, 32'h77);
    chk("x12_busy", a_b1, 1);
    iss_en = 1; iss_rd = 0; rs2 = 0;
    tick();
    idle(); #1;
    chk("x0_never_busy", a_b2, 0);
    chk("x12_still", a_b1, 1);

    iss_en = 1; iss_rd = 4;
    wr_en = 1; rd = 4; wr_data = 32'h99;
    tick();
    idle(); rs1 = 4; #1;
    chk("x4_pre_rd", a_rd1, 32'h99);
    chk("x4_pre_busy", a_b1, 1);
    rst = 1; wr_en = 1; rd = 4; wr_data = 32'h11;
    tick();
    rst = 0; idle(); rs1 = 4; rs2 = 12; #1;
    chk("mrst_rd1", a_rd1, 0);
    chk("mrst_busy1", a_b1, 0);
    chk("mrst_rd2", a_rd2, 0);
    chk("mrst_busy2", a_b2, 0);
    chk("mrst_b_rd1", b_rd1, 0);

    c_wr_en = 1; c_rd = 15; c_wr_data = 64'hFFFF_0000_1234_5678;
    c_iss_en = 1; c_iss_rd = 15;
    tick();
    idle(); c_rs1 = 15; c_rs2 = 14; #1;
    chk("c64_rd", c_rd1, 64'hFFFF_0000_1234_5678);
    chk("c64_busy15", c_b1, 1);
    chk("c64_busy14", c_b2, 0);
    c_wr_en = 1; c_rd = 15; c_wr_data = 64'h8000_0000_0000_0001;
    #1;
    chk("c64_byp", c_rd1, 64'h8000_0000_0000_0001);
    chk("c64_byp_busy", c_b1, 0);
    tick();
    idle(); c_rs2 = 15; #1;
    chk("c64_same_port", c_rd2, 64'h8000_0000_0000_0001);
    chk("c64_busy_clr", c_b2, 0);
    chk("c64_r0", c_rd1 ^ c_rd2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
